// File: rtl/mux21_pkg.sv
// Shared definitions for the MUX21 sequencer: FSM encoding, word size and
// the round-robin winner rule used at every arbitration point.
package mux21_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GAP    = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  localparam int BITS_PER_WORD = 8;

  // A lone requester wins; with both requesting, the channel not served last wins.
  function automatic logic pick_winner(input logic [1:0] req, input logic last_served);
    logic win;
    win = last_served;
    case (req)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      2'b11:   win = ~last_served;
      default: win = last_served;
    endcase
    return win;
  endfunction

endpackage

// File: rtl/mux21_seq_if.sv
// Request/grant and MUX21 cell control bundle between the requesters and the sequencer.
interface mux21_seq_if;
  import mux21_pkg::*;

  logic [1:0]               req;
  logic [1:0]               gnt;
  logic                     s;
  logic                     en_b;
  logic                     y_in;
  logic [BITS_PER_WORD-1:0] dout;
  logic                     dout_valid;
  logic                     dout_src;

  modport master (
    output req, y_in,
    input  gnt, s, en_b, dout, dout_valid, dout_src
  );

  modport slave (
    input  req, y_in,
    output gnt, s, en_b, dout, dout_valid, dout_src
  );

endinterface

// File: rtl/mux21_cap.sv
// Serial-to-parallel capture of the MUX21 Y output: MSB-first shift register,
// bit counter and a one-cycle valid pulse per completed word.
module mux21_cap
  import mux21_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sample,
  input  logic                     y_in,
  input  logic                     src,
  output logic                     word_done,
  output logic [BITS_PER_WORD-1:0] dout,
  output logic                     dout_valid,
  output logic                     dout_src
);

  logic [BITS_PER_WORD-1:0] shreg;
  logic [2:0]               bit_cnt;

  // High on the edge that takes the last bit of a word.
  assign word_done = sample && (bit_cnt == 3'(BITS_PER_WORD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_src   <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      if (sample) begin
        shreg   <= {shreg[BITS_PER_WORD-2:0], y_in};
        bit_cnt <= bit_cnt + 3'd1;
        if (word_done) begin
          dout       <= {shreg[BITS_PER_WORD-2:0], y_in};
          dout_src   <= src;
          dout_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mux21_seq.sv
// Two-channel sequencer for a MUX21 cell: round-robin arbitration with a
// break-before-make gap ahead of every grant and serial capture of Y.
module mux21_seq
  import mux21_pkg::*;
#(
  parameter int GAP   = 1,
  parameter int WORDS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  mux21_seq_if.slave bus
);

  localparam logic [3:0] GAP_LOAD  = 4'(GAP);
  localparam logic [3:0] LAST_WORD = 4'(WORDS - 1);

  state_t     state;
  logic       s;
  logic       en_b;
  logic [1:0] gnt;
  logic       last_served;
  logic [3:0] gap_cnt;
  logic [3:0] word_cnt;
  logic       sample;
  logic       word_done;

  assign sample   = (state == ST_ACTIVE);
  assign bus.s    = s;
  assign bus.en_b = en_b;
  assign bus.gnt  = gnt;

  // s is only ever loaded together with en_b going or staying high, so it
  // settles during the gap before the cell is enabled again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      s           <= 1'b0;
      en_b        <= 1'b1;
      gnt         <= 2'b00;
      last_served <= 1'b1;
      gap_cnt     <= '0;
      word_cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req != 2'b00) begin
            s       <= pick_winner(bus.req, last_served);
            gap_cnt <= GAP_LOAD;
            state   <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_cnt == 4'd1) begin
            gap_cnt  <= '0;
            word_cnt <= '0;
            en_b     <= 1'b0;
            gnt      <= s ? 2'b10 : 2'b01;
            state    <= ST_ACTIVE;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        ST_ACTIVE: begin
          if (word_done) begin
            if (word_cnt == LAST_WORD) begin
              last_served <= s;
              en_b        <= 1'b1;
              gnt         <= 2'b00;
              word_cnt    <= '0;
              if (bus.req != 2'b00) begin
                s       <= pick_winner(bus.req, s);
                gap_cnt <= GAP_LOAD;
                state   <= ST_GAP;
              end else begin
                state <= ST_IDLE;
              end
            end else begin
              word_cnt <= word_cnt + 4'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  mux21_cap u_cap (
    .clk        (clk),
    .rst_n      (rst_n),
    .sample     (sample),
    .y_in       (bus.y_in),
    .src        (s),
    .word_done  (word_done),
    .dout       (bus.dout),
    .dout_valid (bus.dout_valid),
    .dout_src   (bus.dout_src)
  );

endmodule

// File: tb/tb_mux21_seq.sv
// Bench for mux21_seq: two instances (GAP=1/WORDS=1 and GAP=3/WORDS=2) checked
// every cycle against a grant-window reference model plus directed sequences.
module tb_mux21_seq;

  localparam int GAP_P   [2] = '{1, 3};
  localparam int WORDS_P [2] = '{1, 2};

  logic       clk;
  logic       rst_n;
  logic [1:0] req_d [2];
  logic [1:0] y_d;

  logic [1:0] en_b_o, s_o, vld_o, src_o;
  logic [1:0] gnt_o  [2];
  logic [7:0] dout_o [2];

  int n_vec = 0;
  int n_bad = 0;

  mux21_seq_if bus_a ();
  mux21_seq_if bus_b ();

  assign bus_a.req  = req_d[0];
  assign bus_a.y_in = y_d[0];
  assign bus_b.req  = req_d[1];
  assign bus_b.y_in = y_d[1];

  assign en_b_o[0] = bus_a.en_b;       assign en_b_o[1] = bus_b.en_b;
  assign s_o[0]    = bus_a.s;          assign s_o[1]    = bus_b.s;
  assign vld_o[0]  = bus_a.dout_valid; assign vld_o[1]  = bus_b.dout_valid;
  assign src_o[0]  = bus_a.dout_src;   assign src_o[1]  = bus_b.dout_src;
  assign gnt_o[0]  = bus_a.gnt;        assign gnt_o[1]  = bus_b.gnt;
  assign dout_o[0] = bus_a.dout;       assign dout_o[1] = bus_b.dout;

  mux21_seq #(.GAP(1), .WORDS(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
  mux21_seq #(.GAP(3), .WORDS(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each grant is a window of edge numbers computed at the
  // arbitration edge; outputs and captured words follow from that window.
  int         kc [2], next_dec [2], act_lo [2], act_hi [2];
  logic [1:0] win, last, m_enb, m_s, m_vld, m_src;
  logic [7:0] acc [2], m_dout [2];
  logic [1:0] m_gnt [2];
  logic [1:0] prev_s;

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      kc[d] = 0; next_dec[d] = 0; act_lo[d] = -1000; act_hi[d] = -1000;
      win[d] = 1'b0; last[d] = 1'b1; m_enb[d] = 1'b1; m_s[d] = 1'b0;
      m_vld[d] = 1'b0; m_src[d] = 1'b0; acc[d] = '0; m_dout[d] = '0; m_gnt[d] = '0;
    end
  endtask

  task automatic model_edge(input int d);
    int k, idx;
    k = kc[d];
    m_vld[d] = 1'b0;
    if (k > act_lo[d] && k <= act_hi[d] + 1) begin
      idx = k - act_lo[d] - 1;
      acc[d] = {acc[d][6:0], y_d[d]};
      if (idx % 8 == 7) begin
        m_dout[d] = acc[d]; m_src[d] = win[d]; m_vld[d] = 1'b1;
      end
    end
    if (k >= next_dec[d]) begin
      if (req_d[d] != 2'b00) begin
        win[d]      = (req_d[d] == 2'b11) ? ~last[d] : req_d[d][1];
        last[d]     = win[d];
        act_lo[d]   = k + GAP_P[d];
        act_hi[d]   = k + GAP_P[d] + 8 * WORDS_P[d] - 1;
        next_dec[d] = act_hi[d] + 1;
      end else begin
        next_dec[d] = k + 1;
      end
    end
    m_s[d]   = win[d];
    m_enb[d] = !(k >= act_lo[d] && k <= act_hi[d]);
    m_gnt[d] = m_enb[d] ? 2'b00 : (win[d] ? 2'b10 : 2'b01);
    kc[d]    = k + 1;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else for (int d = 0; d < 2; d++) model_edge(d);
    end
  end

  initial begin
    prev_s = 2'b00;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("en_b[%0d]", d), 32'(en_b_o[d]), 32'(m_enb[d]));
        chk($sformatf("gnt[%0d]", d),  32'(gnt_o[d]),  32'(m_gnt[d]));
        chk($sformatf("s[%0d]", d),    32'(s_o[d]),    32'(m_s[d]));
        chk($sformatf("dout_valid[%0d]", d), 32'(vld_o[d]), 32'(m_vld[d]));
        chk($sformatf("dout[%0d]", d), 32'(dout_o[d]), 32'(m_dout[d]));
        chk($sformatf("dout_src[%0d]", d), 32'(src_o[d]), 32'(m_src[d]));
        if (s_o[d] !== prev_s[d]) chk($sformatf("s_switch_en_b[%0d]", d), 32'(en_b_o[d]), 32'd1);
        prev_s[d] = s_o[d];
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_low(input int d, input int budget, output logic ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (en_b_o[d] == 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk($sformatf("grant_timeout[%0d]", d), 32'd0, 32'd1);
  endtask

  typedef struct {
    logic [1:0] req;
    logic [7:0] word;
    logic [7:0] exp_dout;
    logic       exp_src;
  } vec_t;

  vec_t tbl [6];

  initial begin
    logic       ok;
    logic [7:0]  w8;
    logic [15:0] w16;
    int act, gap, np, cyc, idle_ok, ng, gapc, pulses;
    int         pt [4];
    logic [7:0] pd [4];
    logic       ch [5];
    int         acts [5];
    int         gaps [5];
    logic       prev_en;

    tbl[0] = '{2'b01, 8'hB2, 8'hB2, 1'b0};
    tbl[1] = '{2'b10, 8'h5A, 8'h5A, 1'b1};
    tbl[2] = '{2'b01, 8'hFF, 8'hFF, 1'b0};
    tbl[3] = '{2'b10, 8'h00, 8'h00, 1'b1};
    tbl[4] = '{2'b11, 8'h81, 8'h81, 1'b0};
    tbl[5] = '{2'b11, 8'h3C, 8'h3C, 1'b1};

    rst_n = 1'b0; req_d[0] = 2'b00; req_d[1] = 2'b00; y_d = 2'b00;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_en_b[%0d]", d), 32'(en_b_o[d]), 32'd1);
      chk($sformatf("rst_gnt[%0d]", d),  32'(gnt_o[d]),  32'd0);
      chk($sformatf("rst_dout[%0d]", d), 32'(dout_o[d]), 32'd0);
      chk($sformatf("rst_s[%0d]", d),    32'(s_o[d]),    32'd0);
    end
    #1 rst_n = 1'b1;

    // Single grants on the GAP=1/WORDS=1 instance, one word each.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      req_d[0] = tbl[i].req;
      wait_low(0, 10, ok);
      if (!ok) continue;
      chk($sformatf("tbl%0d_s", i), 32'(s_o[0]), 32'(tbl[i].exp_src));
      req_d[0] = 2'b00;
      w8 = tbl[i].word;
      for (int b = 7; b >= 0; b--) begin
        y_d[0] = w8[b];
        @(negedge clk);
      end
      y_d[0] = 1'b0;
      chk($sformatf("tbl%0d_valid", i), 32'(vld_o[0]), 32'd1);
      chk($sformatf("tbl%0d_dout", i),  32'(dout_o[0]), 32'(tbl[i].exp_dout));
      chk($sformatf("tbl%0d_src", i),   32'(src_o[0]),  32'(tbl[i].exp_src));
      repeat (2) @(negedge clk);
    end

    // Request dropped after three active cycles: grant still runs to completion.
    @(negedge clk);
    req_d[0] = 2'b10;
    wait_low(0, 10, ok);
    act = 0; w8 = 8'hC5;
    for (int b = 7; b >= 0; b--) begin
      if (en_b_o[0] == 1'b0) act++;
      y_d[0] = w8[b];
      if (b == 4) req_d[0] = 2'b00;
      @(negedge clk);
    end
    y_d[0] = 1'b0;
    chk("drop_active_len", 32'(act), 32'd8);
    chk("drop_valid", 32'(vld_o[0]), 32'd1);
    chk("drop_dout", 32'(dout_o[0]), 32'hC5);
    chk("drop_src", 32'(src_o[0]), 32'd1);
    idle_ok = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (en_b_o[0] == 1'b1 && gnt_o[0] == 2'b00) idle_ok++;
    end
    chk("drop_idle", 32'(idle_ok), 32'd4);

    // Multi-word grant on the GAP=3/WORDS=2 instance.
    @(negedge clk);
    req_d[1] = 2'b01;
    gap = 0; ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (en_b_o[1] == 1'b1) gap++;
      else begin ok = 1'b1; break; end
    end
    chk("mw_gap_len", 32'(gap), 32'd3);
    req_d[1] = 2'b00;
    act = 0; np = 0; cyc = 0; w16 = 16'h1234;
    for (int b = 15; b >= 0; b--) begin
      if (en_b_o[1] == 1'b0) act++;
      if (vld_o[1] == 1'b1 && np < 4) begin pt[np] = cyc; pd[np] = dout_o[1]; np++; end
      y_d[1] = w16[b];
      @(negedge clk);
      cyc++;
    end
    if (vld_o[1] == 1'b1 && np < 4) begin pt[np] = cyc; pd[np] = dout_o[1]; np++; end
    y_d[1] = 1'b0;
    chk("mw_active_len", 32'(act), 32'd16);
    chk("mw_pulses", 32'(np), 32'd2);
    if (np == 2) begin
      chk("mw_pulse_spacing", 32'(pt[1] - pt[0]), 32'd8);
      chk("mw_word0", 32'(pd[0]), 32'h12);
      chk("mw_word1", 32'(pd[1]), 32'h34);
    end
    repeat (3) @(negedge clk);

    // Reset asserted in the middle of an active grant.
    req_d[0] = 2'b01;
    wait_low(0, 10, ok);
    y_d[0] = 1'b1;
    repeat (3) @(negedge clk);
    req_d[0] = 2'b00;
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("midrst_en_b[%0d]", d), 32'(en_b_o[d]), 32'd1);
      chk($sformatf("midrst_gnt[%0d]", d),  32'(gnt_o[d]),  32'd0);
      chk($sformatf("midrst_dout[%0d]", d), 32'(dout_o[d]), 32'd0);
      chk($sformatf("midrst_valid[%0d]", d), 32'(vld_o[d]), 32'd0);
    end
    @(negedge clk);
    #1 rst_n = 1'b1;
    pulses = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (vld_o[0] == 1'b1) pulses++;
    end
    chk("midrst_no_pulse", 32'(pulses), 32'd0);

    // Contention from reset: both channels held requesting for four grants.
    @(negedge clk);
    req_d[0] = 2'b11;
    #1 rst_n = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    ng = 0; gapc = 0; act = 0; prev_en = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      y_d[0] = 1'($urandom_range(0, 1));
      if (en_b_o[0] == 1'b0) begin
        if (prev_en == 1'b1) begin ch[ng] = gnt_o[0][1]; gaps[ng] = gapc; act = 0; end
        act++;
      end else begin
        if (prev_en == 1'b0) begin acts[ng] = act; ng++; gapc = 0; end
        gapc++;
      end
      prev_en = en_b_o[0];
      if (ng == 4) break;
    end
    req_d[0] = 2'b00;
    chk("rr_grants", 32'(ng), 32'd4);
    if (ng == 4) begin
      for (int g = 0; g < 4; g++) begin
        chk($sformatf("rr_order%0d", g), 32'(ch[g]), 32'(g % 2));
        chk($sformatf("rr_len%0d", g), 32'(acts[g]), 32'd8);
        if (g > 0) chk($sformatf("rr_gap%0d", g), 32'(gaps[g]), 32'd1);
      end
    end
    repeat (20) @(negedge clk);

    // Randomized traffic on both instances, checked by the reference model.
    for (int n = 0; n < 1200; n++) begin
      for (int d = 0; d < 2; d++) begin
        if ($urandom_range(0, 7) == 0) req_d[d] = 2'($urandom_range(0, 3));
        y_d[d] = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
    end
    req_d[0] = 2'b00; req_d[1] = 2'b00;
    repeat (40) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mux21_seq.md
MUX21_SEQ -- requirements
Module: mux21_seq

Interface
REQ-001 Parameter GAP, default 1: break-before-make cycles (en_b high) before every grant; legal range 1..15.
REQ-002 Parameter WORDS, default 1: 8-bit words captured per grant; legal range 1..16.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req  input  2  request from channel 0/1 for the mux path; level-sensitive.
REQ-006 gnt  output  2  one-hot grant; high only while the channel's data is being captured.
REQ-007 s  output  1  select to the downstream MUX21 cell (0 = D0, 1 = D1).
REQ-008 en_b  output  1  active-low enable to the MUX21 cell.
REQ-009 y_in  input  1  MUX21 Y output, returned for serial capture.
REQ-010 dout  output  8  last completed captured word, first sample in bit 7.
REQ-011 dout_valid  output  1  one-cycle pulse: dout holds a new word.
REQ-012 dout_src  output  1  channel that produced dout.

Function
REQ-013 s, en_b, gnt, dout, dout_valid, dout_src SHALL all be driven from flops; there SHALL be no combinational input-to-output path.
REQ-014 FSM states SHALL be IDLE, GAP, ACTIVE.
REQ-015 IDLE: en_b=1, gnt=0; if req != 0, choose winner, load s with winner, load gap counter with GAP, go to GAP next cycle.
REQ-016 Winner: single requester wins; both requesting -> the channel not in last_served wins (round robin).
REQ-017 GAP: en_b=1, gnt=0, s stable; after exactly GAP cycles go to ACTIVE.
REQ-018 ACTIVE: en_b=0, gnt[s]=1 for exactly 8*WORDS cycles; s SHALL NOT change in ACTIVE.
REQ-019 Each ACTIVE cycle, y_in SHALL be sampled at the rising edge ending that cycle and shifted into an 8-bit register, MSB first.
REQ-020 After every 8th sample, dout and dout_src SHALL update and dout_valid SHALL be high the following cycle only.
REQ-021 Grants are non-preemptive: dropping req during ACTIVE SHALL NOT shorten the grant.
REQ-022 At end of ACTIVE, last_served := s; if req != 0, arbitrate per REQ-016 and go to GAP (en_b stays high at least GAP cycles); else go to IDLE.
REQ-023 s SHALL change only while en_b=1 and is at least one cycle before en_b falls (glitch-free switching).
REQ-024 dout holds its value between pulses; dout_valid pulse may coincide with a transition to GAP/IDLE.
REQ-025 Counters: gap counter 4 bits, bit counter 3 bits wrapping 7->0, word counter 4 bits; no wrap-induced extra grant cycles.

Reset
REQ-026 On rst_n low, immediately: state=IDLE, s=0, en_b=1, gnt=0, dout=8'h00, dout_valid=0, dout_src=0, last_served=1, all counters 0.
REQ-027 Reset mid-ACTIVE SHALL discard the partial word; no dout_valid after release.
REQ-028 First arbitration after reset release SHALL occur on the first rising edge with rst_n high.

Structure
REQ-029 State encoding (IDLE/GAP/ACTIVE) and the constant 8 (bits per word) SHALL reside in shared package mux21_pkg.
REQ-030 The serial-to-parallel capture SHALL be a sub-module mux21_cap (shift register, bit counter, valid pulse); arbitration/FSM stays in mux21_seq.

Verification
REQ-031 Reset: rst_n low mid-ACTIVE -> same-cycle en_b=1, gnt=0, dout=00, dout_valid=0; no pulse after release.
REQ-032 Single request: GAP=1, WORDS=1, req=01, y_in stream 1,0,1,1,0,0,1,0 -> s=0, en_b low 8 cycles after 1 gap cycle, dout=8'hB2, dout_src=0, one pulse.
REQ-033 Contention: req=11 from reset -> channel 0 granted first, then GAP, then channel 1; s toggles only while en_b=1.
REQ-034 Round robin: req held 11 for 4 grants -> grant order 0,1,0,1; every grant exactly 8 cycles, every gap exactly GAP cycles.
REQ-035 Drop during grant: req=10 then 00 after 3 ACTIVE cycles -> grant completes 8 cycles, word delivered with dout_src=1, then IDLE.
REQ-036 Multi-word: WORDS=2, GAP=3, req=01 -> 3 gap cycles, 16 active cycles, two dout_valid pulses 8 cycles apart.
